// File: rtl/register32_pkg.sv
// Shared datapath constants for word-wide storage elements.
package register32_pkg;

    localparam int DATA_WIDTH = 32;

    typedef logic [DATA_WIDTH-1:0] word_t;

endpackage : register32_pkg

// File: rtl/register32.sv
// Word-wide storage register with synchronous clear and load enable.
// Clear wins over load, and the register holds its value when neither is asserted.
module register32
    import register32_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    output logic [WIDTH-1:0] Q,
    input  logic [WIDTH-1:0] D,
    input  logic             LE,
    input  logic             Clr,
    input  logic             Clk
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge Clk) begin
        if (Clr) begin
            r_q <= '0;
        end else if (LE) begin
            r_q <= D;
        end
    end

    // Q comes straight from the flops, so there is no path from D to Q.
    assign Q = r_q;

endmodule : register32

// File: tb/tb_register32.sv
// Scoreboard bench for register32: the stimulus pushes expected words and a monitor checks each edge.
module tb_register32;

    localparam int W = 32;

    logic [W-1:0] Q;
    logic [W-1:0] D;
    logic         LE;
    logic         Clr;
    logic         Clk;

    typedef struct {
        string        name;
        logic [W-1:0] val;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] model_q;
    bit           model_known = 0;
    logic [W-1:0] q_ones;
    logic [W-1:0] q_zeros;

    register32 #(.WIDTH(W)) dut (
        .Q   (Q),
        .D   (D),
        .LE  (LE),
        .Clr (Clr),
        .Clk (Clk)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Storage rule: clear gives zero, load takes D, otherwise keep the old word.
    function automatic logic [W-1:0] ref_next(input logic clr, input logic le,
                                              input logic [W-1:0] d, input logic [W-1:0] prev);
        if (clr) return '0;
        if (le)  return d;
        return prev;
    endfunction

    task automatic drive(input logic clr, input logic le, input logic [W-1:0] d, input string name);
        logic [W-1:0] prev;
        @(negedge Clk);
        Clr = clr;
        LE  = le;
        D   = d;
        prev = model_q;
        if (clr || le || model_known) begin
            model_q = ref_next(clr, le, d, model_q);
            model_known = 1;
            sb.push_back('{name: name, val: model_q});
        end
        #1;
        if (model_known && (clr || le ? 1'b1 : 1'b1) && prev !== 'x)
            check({name, "_before_edge"}, Q, prev);
    endtask

    always @(posedge Clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.name, Q, e.val);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_q = 'x;
        Clr = 1'b0;
        LE  = 1'b0;
        D   = '0;
        repeat (2) @(negedge Clk);

        drive(1'b1, 1'b1, 32'h1234_5678, "clear");
        drive(1'b0, 1'b1, 32'hAAAA_FFFF, "load");
        for (int i = 0; i < 5; i++)
            drive(1'b0, 1'b0, 32'h5555_0000, "hold");

        drive(1'b1, 1'b1, 32'hFFFF_FFFF, "clr_priority");
        drive(1'b0, 1'b1, 32'hFFFF_FFFF, "load_after_clr");

        // Short clear pulse entirely between two rising edges.
        drive(1'b0, 1'b1, 32'hAAAA_FFFF, "reload");
        @(negedge Clk);
        LE  = 1'b0;
        Clr = 1'b0;
        sb.push_back('{name: "short_pulse_edge", val: model_q});
        #1 Clr = 1'b1;
        #3 Clr = 1'b0;
        #1 check("short_pulse_mid", Q, 32'hAAAA_FFFF);

        for (int i = 0; i < 4; i++)
            drive(1'b0, 1'b1, W'(i), "consecutive");

        drive(1'b0, 1'b1, 32'hFFFF_FFFF, "all_ones");
        @(posedge Clk);
        #2 q_ones = Q;
        drive(1'b0, 1'b1, 32'h0000_0000, "all_zeros");
        @(posedge Clk);
        #2 q_zeros = Q;
        check("toggle_all_bits", q_ones ^ q_zeros, 32'hFFFF_FFFF);

        for (int i = 0; i < 300; i++)
            drive(($urandom_range(7) == 0), $urandom_range(1) == 1, $urandom, "random");

        @(negedge Clk);
        LE  = 1'b0;
        Clr = 1'b0;
        model_q = ref_next(1'b0, 1'b0, D, model_q);
        sb.push_back('{name: "final_hold", val: model_q});
        repeat (2) @(negedge Clk);
        check("scoreboard_drained", W'(sb.size()), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_register32

// File: doc/register32.md
# register32

32-bit general-purpose storage register with synchronous clear and load enable. It is the basic word-wide state element of the datapath, used for register-file entries and pipeline/holding registers. All state changes occur on the rising clock edge, and the stored word is driven continuously on `Q`.

## Interface
Parameters:
- `WIDTH`, default 32: data width. Instances in the datapath use the default.

Ports, listed clock and reset first:
- `Clk`, input, 1: system clock. The register is sampled on the rising edge.
- `Clr`, input, 1: reset/clear. One clock; reset is synchronous and active-high.
- `LE`, input, 1: load enable, active-high.
- `D`, input, WIDTH: data to load.
- `Q`, output, WIDTH: stored word, driven directly from the register.

Positional port order is fixed as (`Q`, `D`, `LE`, `Clr`, `Clk`). Existing instantiations connect by position.

## Operation
At each rising edge of `Clk`, evaluated in priority order:
- `Clr` = 1: `Q` <= 0, regardless of `LE` and `D`.
- `Clr` = 0 and `LE` = 1: `Q` <= `D`, all bits captured in the same edge.
- `Clr` = 0 and `LE` = 0: `Q` holds its previous value.

Additional rules:
- Clear has priority over load. If both are high at an edge, the result is 0.
- Reset value of `Q` is 32'h0000_0000.
- Before the first clearing or loading edge, `Q` is unknown. Users must clear or load before the first read.
- Changes on `D`, `LE` or `Clr` between rising edges have no effect on `Q`.
- There is no asynchronous path from any input to `Q`, and no combinational path from `D` to `Q`.
- The register has no wrap-around, overflow or arithmetic behaviour. It is pure storage.

## Timing
- Latency is one clock. A value presented on `D` with `LE` = 1 at edge N appears on `Q` immediately after edge N.
- A clear asserted at edge N gives `Q` = 0 after edge N.
- A `Clr` or `LE` pulse that does not span a rising edge is ignored.
- `D`, `LE` and `Clr` must meet setup and hold time around the rising edge. Inputs that change exactly at the edge have undefined results at RTL level, so benches must drive inputs away from the active edge.
- `Q` is stable for the full clock period after each edge.
- Back-to-back loads on consecutive edges are supported. Each edge captures the `D` present at that edge.

## Structure
- A shared package is not required. `WIDTH` is a local parameter with default 32; a common data-width constant may supply it if one exists in the project package.
- The block is a single module, `register32`, containing one clocked process with clear/load/hold priority.
- No sub-modules are needed. A per-bit flop cell is not used.

## Test plan
1. **Clear:** `D` = 32'h1234_5678, `LE` = 1, `Clr` = 1 across one rising edge -> `Q` = 32'h0000_0000 after that edge.
2. **Load:** `Clr` = 0, `LE` = 1, `D` = 32'hAAAA_FFFF at an edge -> `Q` = 32'hAAAA_FFFF after that edge, not before.
3. **Hold:** `LE` = 0, `Clr` = 0, `D` changed to 32'h5555_0000 for 5 edges -> `Q` stays 32'hAAAA_FFFF.
4. **Clear priority:** `LE` = 1, `Clr` = 1, `D` = 32'hFFFF_FFFF at an edge -> `Q` = 0. Then deassert `Clr` with `LE` = 1 -> `Q` = 32'hFFFF_FFFF at the next edge.
5. **Short pulse:** `Clr` pulse of 3 time units placed entirely between rising edges while `Q` = 32'hAAAA_FFFF -> `Q` unchanged.
6. **Consecutive loads:** `LE` = 1 with `D` = 0, 1, 2, 3 on successive edges -> `Q` follows 0, 1, 2, 3 with a one-cycle delay. Also check that an all-ones to all-zeros transition toggles every bit.
